// File: rtl/pcie_bar_cmd_decoder.sv
// BAR0 command decoder: parses single-DW host MWr TLPs into byte-swapped DMA address registers.
// Define CPL_RD_EN to also answer 1-DW host MRd with single-beat CplD TLPs.
module pcie_bar_cmd_decoder #(
  parameter logic [11:0] OFF_ADDR0   = 12'h100,
  parameter logic [11:0] OFF_ADDR1   = 12'h120,
  parameter logic [11:0] OFF_ADDR2   = 12'h140,
  parameter logic [11:0] OFF_ADDR_HI = 12'h160,
  parameter logic [11:0] OFF_CTRL    = 12'h180
) (
  input  logic         pcie_clk,
  input  logic         rstn,
  input  logic         axis_master_tvalid,
  output logic         axis_master_tready,
  input  logic [127:0] axis_master_tdata,
  input  logic [3:0]   axis_master_tkeep,
  input  logic         axis_master_tlast,
  input  logic [7:0]   axis_master_tuser,
  input  logic [7:0]   ep_bus_num,
  input  logic [4:0]   ep_dev_num,
  output logic [31:0]  dma_addr0,
  output logic [31:0]  dma_addr1,
  output logic [31:0]  dma_addr2,
  output logic [31:0]  dma_addr_high,
  output logic         dma_addr_valid,
  output logic [15:0]  drop_cnt,
  output logic         cpl_tvalid,
  input  logic         cpl_tready,
  output logic [127:0] cpl_tdata,
  output logic         cpl_tlast
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_DROP, S_CPL} state_t;

  state_t      r_state, w_next_state;
  logic [11:0] r_off;
  logic [15:0] r_req_id;
  logic [7:0]  r_tag;
  logic [31:0] r_addr0, r_addr1, r_addr2, r_addr_hi, r_ctrl;
  logic        r_valid;
  logic [15:0] r_drop_cnt;

  logic        w_beat, w_is_mwr, w_is_mrd, w_drop, w_wr;
  logic [7:0]  w_ft;
  logic [9:0]  w_len;
  logic [31:0] w_wr_data;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign axis_master_tready = (r_state != S_CPL);
  assign w_beat    = axis_master_tvalid && axis_master_tready;
  assign w_ft      = axis_master_tdata[31:24];
  assign w_len     = axis_master_tdata[9:0];
  assign w_wr_data = bswap(axis_master_tdata[31:0]);
  // A MWr header with tlast set carries no payload and is treated as malformed.
  assign w_is_mwr  = (w_ft == 8'h40) && (w_len == 10'd1) && !axis_master_tlast;
`ifdef CPL_RD_EN
  assign w_is_mrd  = (w_ft == 8'h00) && (w_len == 10'd1) && axis_master_tlast;
`else
  assign w_is_mrd  = 1'b0;
`endif

  always_ff @(posedge pcie_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) r_state <= S_HDR;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_drop       = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_HDR: if (w_beat) begin
        if (w_is_mwr)      w_next_state = S_DATA;
        else if (w_is_mrd) w_next_state = S_CPL;
        else begin
          w_drop       = 1'b1;
          w_next_state = axis_master_tlast ? S_HDR : S_DROP;
        end
      end
      S_DATA: if (w_beat) begin
        w_wr         = 1'b1;
        w_next_state = axis_master_tlast ? S_HDR : S_DROP;
      end
      S_DROP:  if (w_beat && axis_master_tlast) w_next_state = S_HDR;
      S_CPL:   if (cpl_tready) w_next_state = S_HDR;
      default: w_next_state = S_HDR;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (!rstn) begin
      r_off      <= '0;
      r_req_id   <= '0;
      r_tag      <= '0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_addr_hi  <= '0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == S_HDR && w_beat) begin
        r_off    <= axis_master_tdata[75:64];
        r_req_id <= axis_master_tdata[63:48];
        r_tag    <= axis_master_tdata[47:40];
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      // Unmatched offsets fall through silently; they are not drops.
      if (w_wr) begin
        case (r_off)
          OFF_ADDR0:   r_addr0   <= w_wr_data;
          OFF_ADDR1:   r_addr1   <= w_wr_data;
          OFF_ADDR2:   r_addr2   <= w_wr_data;
          OFF_ADDR_HI: r_addr_hi <= w_wr_data;
          OFF_CTRL:    r_ctrl    <= w_wr_data;
          default:     ;
        endcase
      end
      r_valid <= (r_addr0 != '0) && (r_addr1 != '0) && (r_addr2 != '0) && r_ctrl[0];
    end
  end

  assign dma_addr0      = r_addr0;
  assign dma_addr1      = r_addr1;
  assign dma_addr2      = r_addr2;
  assign dma_addr_high  = r_addr_hi;
  assign dma_addr_valid = r_valid;
  assign drop_cnt       = r_drop_cnt;

`ifdef CPL_RD_EN
  logic [31:0] w_rd_data;
  logic        w_unused;

  always_comb begin
    w_rd_data = '0;
    case (r_off)
      OFF_ADDR0:   w_rd_data = r_addr0;
      OFF_ADDR1:   w_rd_data = r_addr1;
      OFF_ADDR2:   w_rd_data = r_addr2;
      OFF_ADDR_HI: w_rd_data = r_addr_hi;
      OFF_CTRL:    w_rd_data = r_ctrl;
      default:     w_rd_data = '0;
    endcase
  end

  // Registers hold host-swapped values, so swapping again returns the host's byte order.
  assign cpl_tvalid = (r_state == S_CPL);
  assign cpl_tlast  = cpl_tvalid;
  assign cpl_tdata  = cpl_tvalid ?
                      {bswap(w_rd_data),
                       r_req_id, r_tag, 1'b0, r_off[6:0],
                       ep_bus_num, ep_dev_num, 3'b000, 4'h0, 12'd4,
                       3'b010, 5'b01010, 14'd0, 10'd1} : '0;
  assign w_unused   = ^{axis_master_tkeep, axis_master_tuser, axis_master_tdata};
`else
  logic w_unused;

  assign cpl_tvalid = 1'b0;
  assign cpl_tlast  = 1'b0;
  assign cpl_tdata  = '0;
  assign w_unused   = ^{axis_master_tkeep, axis_master_tuser, axis_master_tdata,
                        ep_bus_num, ep_dev_num, r_req_id, r_tag};
`endif

endmodule

// File: tb/tb_pcie_bar_cmd_decoder.sv
// Self-checking bench for pcie_bar_cmd_decoder: table of MWr vectors plus hand-written
// sequences for enable timing, multi-beat drops, tvalid gaps, CplD back-pressure and reset.
module tb_pcie_bar_cmd_decoder;

  logic         pcie_clk = 1'b0;
  logic         rstn;
  logic         tvalid;
  logic         tready;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic         tlast;
  logic [7:0]   tuser;
  logic [7:0]   bus_num;
  logic [4:0]   dev_num;
  logic [31:0]  addr0, addr1, addr2, addr_hi;
  logic         addr_valid;
  logic [15:0]  drops;
  logic         c_tvalid, c_tready, c_tlast;
  logic [127:0] c_tdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_drop;

  always #5 pcie_clk = ~pcie_clk;

  pcie_bar_cmd_decoder dut (
    .pcie_clk           (pcie_clk),
    .rstn               (rstn),
    .axis_master_tvalid (tvalid),
    .axis_master_tready (tready),
    .axis_master_tdata  (tdata),
    .axis_master_tkeep  (tkeep),
    .axis_master_tlast  (tlast),
    .axis_master_tuser  (tuser),
    .ep_bus_num         (bus_num),
    .ep_dev_num         (dev_num),
    .dma_addr0          (addr0),
    .dma_addr1          (addr1),
    .dma_addr2          (addr2),
    .dma_addr_high      (addr_hi),
    .dma_addr_valid     (addr_valid),
    .drop_cnt           (drops),
    .cpl_tvalid         (c_tvalid),
    .cpl_tready         (c_tready),
    .cpl_tdata          (c_tdata),
    .cpl_tlast          (c_tlast)
  );

  typedef struct {
    logic [7:0]  ft;
    logic [9:0]  len;
    logic [11:0] off;
    logic [31:0] data;
    int          extra;
    logic [31:0] e_a0, e_a1, e_a2, e_hi;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] hdr(input logic [7:0] ft, input logic [9:0] len,
                                       input logic [11:0] off, input logic [15:0] rid,
                                       input logic [7:0] tag);
    logic [127:0] d;
    d = '0;
    d[31:24] = ft;
    d[9:0]   = len;
    d[63:48] = rid;
    d[47:40] = tag;
    d[75:64] = off;
    return d;
  endfunction

  task automatic beat(input logic [127:0] d, input logic last);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    @(posedge pcie_clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
  endtask

  task automatic mwr(input logic [11:0] off, input logic [31:0] data);
    beat(hdr(8'h40, 10'd1, off, 16'h0, 8'h0), 1'b0);
    beat({96'h0, data}, 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pcie_clk);
    #1;
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] exp_cpl;

    vecs[0] = '{8'h40, 10'd1, 12'h100, 32'h00100078, 0, 32'h78001000, 32'h0, 32'h0, 32'h0, 16'd0};
    vecs[1] = '{8'h40, 10'd1, 12'h120, 32'h11223344, 0, 32'h78001000, 32'h44332211, 32'h0, 32'h0, 16'd0};
    vecs[2] = '{8'h40, 10'd1, 12'h140, 32'hAABBCCDD, 0, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h0, 16'd0};
    vecs[3] = '{8'h40, 10'd1, 12'h160, 32'h01000000, 0, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h1, 16'd0};
    vecs[4] = '{8'h40, 10'd1, 12'h1A0, 32'hFFFFFFFF, 0, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h1, 16'd0};
    vecs[5] = '{8'h60, 10'd1, 12'h100, 32'h12345678, 0, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h1, 16'd1};
    vecs[6] = '{8'h40, 10'd2, 12'h120, 32'h99999999, 1, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h1, 16'd2};
    vecs[7] = '{8'h00, 10'd1, 12'h120, 32'h55555555, 0, 32'h78001000, 32'h44332211, 32'hDDCCBBAA, 32'h1, 16'd3};

    rstn     = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    tkeep    = 4'hF;
    tlast    = 1'b0;
    tuser    = 8'h0;
    bus_num  = 8'h12;
    dev_num  = 5'h03;
    c_tready = 1'b0;

    tick(3);
    check("rst_addr0", addr0, 0);
    check("rst_hi", addr_hi, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_drop", drops, 0);
    check("rst_cpl_tvalid", c_tvalid, 0);
    check("rst_tready", tready, 1);
    rstn = 1'b1;
    tick(1);

    foreach (vecs[i]) begin
      beat(hdr(vecs[i].ft, vecs[i].len, vecs[i].off, 16'h0, 8'h0), 1'b0);
      for (int k = 0; k < vecs[i].extra; k++) beat({96'h0, vecs[i].data}, 1'b0);
      beat({96'h0, vecs[i].data}, 1'b1);
      check($sformatf("vec%0d_addr0", i), addr0, vecs[i].e_a0);
      check($sformatf("vec%0d_addr1", i), addr1, vecs[i].e_a1);
      check($sformatf("vec%0d_addr2", i), addr2, vecs[i].e_a2);
      check($sformatf("vec%0d_hi", i), addr_hi, vecs[i].e_hi);
      check($sformatf("vec%0d_drop", i), drops, vecs[i].e_drop);
      check($sformatf("vec%0d_valid", i), addr_valid, 0);
    end
    exp_drop = 16'd3;

    // dma_en: registered valid appears one edge after the ctrl write lands
    mwr(12'h180, 32'h01000000);
    check("valid_same_cycle", addr_valid, 0);
    tick(1);
    check("valid_rise", addr_valid, 1);
    mwr(12'h120, 32'h00000000);
    check("addr1_zero", addr1, 0);
    tick(1);
    check("valid_fall", addr_valid, 0);
    mwr(12'h120, 32'h11223344);
    tick(1);
    check("valid_restore", addr_valid, 1);

    // Multi-beat MWr is dropped as one TLP; payload ignored
    beat(hdr(8'h40, 10'd32, 12'h100, 16'h0, 8'h0), 1'b0);
    beat({96'h0, 32'hCAFECAFE}, 1'b0);
    beat({96'h0, 32'hCAFECAFE}, 1'b1);
    exp_drop++;
    mwr(12'h160, 32'hDEADBEEF);
    check("len32_drop", drops, exp_drop);
    check("len32_addr0", addr0, 32'h78001000);
    check("len32_hi", addr_hi, 32'hEFBEADDE);

    // tvalid gap between header and data
    beat(hdr(8'h40, 10'd1, 12'h100, 16'h0, 8'h0), 1'b0);
    tick(5);
    beat({96'h0, 32'h04030201}, 1'b1);
    check("gap_addr0", addr0, 32'h01020304);
    check("gap_drop", drops, exp_drop);

    // Malformed MWr (tlast on header) stays in header state
    beat(hdr(8'h40, 10'd1, 12'h100, 16'h0, 8'h0), 1'b1);
    exp_drop++;
    mwr(12'h140, 32'h00000055);
    check("malformed_drop", drops, exp_drop);
    check("malformed_addr0", addr0, 32'h01020304);
    check("malformed_next_addr2", addr2, 32'h55000000);
    check("malformed_valid", addr_valid, 1);

`ifdef CPL_RD_EN
    exp_cpl = {32'h11223344, 32'hBEEF0720, 32'h12180004, 32'h4A000001};
    c_tready = 1'b0;
    beat(hdr(8'h00, 10'd1, 12'h120, 16'hBEEF, 8'h07), 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cpl_hold%0d_tready", k), tready, 0);
      check($sformatf("cpl_hold%0d_tvalid", k), c_tvalid, 1);
      check($sformatf("cpl_hold%0d_tlast", k), c_tlast, 1);
      check($sformatf("cpl_hold%0d_tdata", k), c_tdata, exp_cpl);
      tick(1);
    end
    c_tready = 1'b1;
    tick(1);
    check("cpl_done_tvalid", c_tvalid, 0);
    check("cpl_done_tready", tready, 1);
    check("cpl_drop", drops, exp_drop);
    beat(hdr(8'h00, 10'd1, 12'h1A0, 16'h1234, 8'h09), 1'b1);
    got = c_tdata;
    check("cpl_unmapped_dw3", got[127:96], 0);
    check("cpl_unmapped_dw2", got[95:64], 32'h12340920);
    tick(1);
    check("cpl_unmapped_done", c_tvalid, 0);
    c_tready = 1'b0;
`else
    exp_cpl = '0;
    beat(hdr(8'h00, 10'd1, 12'h120, 16'hBEEF, 8'h07), 1'b1);
    exp_drop++;
    check("mrd_drop", drops, exp_drop);
    check("mrd_cpl_tvalid", c_tvalid, 0);
    check("mrd_cpl_tdata", c_tdata, exp_cpl);
    check("mrd_tready", tready, 1);
`endif

    // Reset between header and data beat of an MWr
    beat(hdr(8'h40, 10'd1, 12'h100, 16'h0, 8'h0), 1'b0);
    rstn = 1'b0;
    tick(2);
    check("midrst_addr0", addr0, 0);
    check("midrst_addr2", addr2, 0);
    check("midrst_hi", addr_hi, 0);
    check("midrst_valid", addr_valid, 0);
    check("midrst_drop", drops, 0);
    check("midrst_cpl", c_tvalid, 0);
    rstn = 1'b1;
    mwr(12'h160, 32'hAABBCCDD);
    check("postrst_hi", addr_hi, 32'hDDCCBBAA);
    check("postrst_addr0", addr0, 0);
    check("postrst_drop", drops, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
